// File: rtl/ika2151_acc_mixer.sv
// Per-sample output accumulator: sums carrier outputs of all 32 slots into
// left/right sums, substitutes the noise sample on slot 31 when enabled, and
// once per frame latches the saturated (or truncated) sums with a strobe.
module ika2151_acc_mixer #(
  parameter int ACC_W  = 19,
  parameter int OUT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_MRST,
  input  logic                    i_phi1_NCEN_n,
  input  logic                    i_SYNC,
  input  logic signed [13:0]      i_OP_DATA,
  input  logic                    i_ACC_EN,
  input  logic [1:0]              i_RL,
  input  logic                    i_NE,
  input  logic signed [13:0]      i_NOISE,
  output logic signed [OUT_W-1:0] o_ACC_L,
  output logic signed [OUT_W-1:0] o_ACC_R,
  output logic                    o_SAMPLE_STB,
  output logic [4:0]              o_SLOT
);

  localparam logic [4:0] LAST_SLOT = 5'd31;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  // Two's complement: bitwise inverse of the maximum is the minimum.
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [4:0]              counter;
  logic [4:0]              slot;
  logic                    enable;
  logic                    last_slot;
  logic signed [13:0]      src;
  logic signed [ACC_W-1:0] src_ext;
  logic signed [ACC_W-1:0] contrib_l, contrib_r;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [ACC_W-1:0] sum_l, sum_r;

  // Clamp to the output range, or keep the low bits when saturation is off.
  function automatic logic signed [OUT_W-1:0] clip(input logic signed [ACC_W-1:0] v);
    if (!SAT_EN)      return v[OUT_W-1:0];
    if (v > OUT_MAX)  return OUT_MAX[OUT_W-1:0];
    if (v < OUT_MIN)  return OUT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  // Slot decode, source selection and next partial sums.
  always_comb begin
    enable    = ~i_phi1_NCEN_n;
    slot      = i_SYNC ? 5'd0 : counter;
    last_slot = (slot == LAST_SLOT);
    src       = (last_slot && i_NE) ? i_NOISE : i_OP_DATA;
    src_ext   = {{(ACC_W - 14){src[13]}}, src};
    contrib_l = (i_ACC_EN && i_RL[0]) ? src_ext : '0;
    contrib_r = (i_ACC_EN && i_RL[1]) ? src_ext : '0;
    // Slot 0 starts a fresh frame, discarding any stale partial sum.
    sum_l     = ((slot == 5'd0) ? '0 : acc_l) + contrib_l;
    sum_r     = ((slot == 5'd0) ? '0 : acc_r) + contrib_r;
  end

  // Slot counter, accumulators, output latch and strobe.
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      counter      <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      o_ACC_L      <= '0;
      o_ACC_R      <= '0;
      o_SAMPLE_STB <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read above sees
      // the pre-edge value; the strobe default makes it exactly one clock wide.
      o_SAMPLE_STB <= 1'b0;
      if (enable) begin
        counter <= slot + 5'd1;
        if (last_slot) begin
          o_ACC_L      <= clip(sum_l);
          o_ACC_R      <= clip(sum_r);
          acc_l        <= '0;
          acc_r        <= '0;
          o_SAMPLE_STB <= 1'b1;
        end else begin
          acc_l <= sum_l;
          acc_r <= sum_r;
        end
      end
    end
  end

  assign o_SLOT = counter;

endmodule

// File: tb/tb_ika2151_acc_mixer.sv
// Scoreboard bench for ika2151_acc_mixer: stimulus pushes hand-computed frame
// results, a monitor pops and compares them whenever a strobe appears.
module tb_ika2151_acc_mixer;

  logic               clk = 1'b0;
  logic               mrst;
  logic               ncen_n;
  logic               sync;
  logic signed [13:0] op_data;
  logic               acc_en;
  logic [1:0]         rl;
  logic               ne;
  logic signed [13:0] noise;

  logic signed [15:0] acc_l, acc_r, acc_l_t, acc_r_t;
  logic               stb, stb_t;
  logic [4:0]         slot, slot_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] lt;
    logic [15:0] rt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic prev_stb = 1'b0;

  always #5 clk = ~clk;

  ika2151_acc_mixer #(.ACC_W(19), .OUT_W(16), .SAT_EN(1'b1)) u_dut (
    .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen_n), .i_SYNC(sync),
    .i_OP_DATA(op_data), .i_ACC_EN(acc_en), .i_RL(rl), .i_NE(ne), .i_NOISE(noise),
    .o_ACC_L(acc_l), .o_ACC_R(acc_r), .o_SAMPLE_STB(stb), .o_SLOT(slot)
  );

  ika2151_acc_mixer #(.ACC_W(19), .OUT_W(16), .SAT_EN(1'b0)) u_dut_trunc (
    .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen_n), .i_SYNC(sync),
    .i_OP_DATA(op_data), .i_ACC_EN(acc_en), .i_RL(rl), .i_NE(ne), .i_NOISE(noise),
    .o_ACC_L(acc_l_t), .o_ACC_R(acc_r_t), .o_SAMPLE_STB(stb_t), .o_SLOT(slot_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r,
                          input logic [15:0] lt, input logic [15:0] rt);
    exp_t e;
    e.l = l; e.r = r; e.lt = lt; e.rt = rt;
    exp_q.push_back(e);
  endtask

  // One enabled cycle, then 0..max_gap disabled cycles carrying junk inputs.
  task automatic drive_cycle(input logic s, input logic signed [13:0] op, input logic en,
                             input logic [1:0] chan, input logic n_en,
                             input logic signed [13:0] nz, input int max_gap);
    int gap;
    sync = s; op_data = op; acc_en = en; rl = chan; ne = n_en; noise = nz; ncen_n = 1'b0;
    @(posedge clk); #1;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
    for (int g = 0; g < gap; g++) begin
      ncen_n = 1'b1; sync = 1'b1; acc_en = 1'b1; rl = 2'b11;
      op_data = 14'sd4321; noise = 14'sd1234; ne = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Runs n_slots enabled cycles; carrier on slot index `active` (-1 = all slots).
  task automatic run_frame(input int active, input logic signed [13:0] op,
                           input logic [1:0] chan, input logic n_en,
                           input logic signed [13:0] nz, input int max_gap,
                           input int n_slots, input logic use_sync);
    for (int s = 0; s < n_slots; s++)
      drive_cycle(use_sync && (s == 0), op, (active < 0) || (s == active),
                  chan, n_en, nz, max_gap);
    ncen_n = 1'b1; sync = 1'b0; acc_en = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expectation and be one clock wide.
  always @(negedge clk) begin
    if (stb === 1'b1 || stb_t === 1'b1) begin
      check("strobe_pair", {31'd0, stb_t}, {31'd0, stb});
      check("strobe_width", {31'd0, prev_stb}, 32'd0);
      check("strobe_slot_wrap", {27'd0, slot}, 32'd0);
      check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("acc_l_sat", {16'd0, acc_l}, {16'd0, e.l});
        check("acc_r_sat", {16'd0, acc_r}, {16'd0, e.r});
        check("acc_l_trunc", {16'd0, acc_l_t}, {16'd0, e.lt});
        check("acc_r_trunc", {16'd0, acc_r_t}, {16'd0, e.rt});
      end
    end
    prev_stb = stb;
  end

  initial begin
    mrst = 1'b1; ncen_n = 1'b1; sync = 1'b0; op_data = '0; acc_en = 1'b0;
    rl = 2'b00; ne = 1'b0; noise = '0;
    repeat (3) @(posedge clk);
    #1 mrst = 1'b0;
    @(negedge clk);
    check("por_slot", {27'd0, slot}, 32'd0);
    check("por_acc_l", {16'd0, acc_l}, 32'd0);

    // Single carrier at slot 5, both channels.
    push_exp(16'd1000, 16'd1000, 16'd1000, 16'd1000);
    run_frame(5, 14'sd1000, 2'b11, 1'b0, 14'sd0, 0, 32, 1'b1);

    // Reset mid-frame: partial sum dropped, outputs cleared, no strobe.
    run_frame(5, 14'sd2000, 2'b11, 1'b0, 14'sd0, 0, 11, 1'b1);
    mrst = 1'b1; ncen_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_acc_l", {16'd0, acc_l}, 32'd0);
    check("rst_acc_r", {16'd0, acc_r}, 32'd0);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_slot", {27'd0, slot}, 32'd0);
    mrst = 1'b0; ncen_n = 1'b1;
    @(posedge clk); #1;
    // 32 enabled cycles without SYNC: counter starts from 0 after reset.
    push_exp(16'd123, 16'd123, 16'd123, 16'd123);
    run_frame(5, 14'sd123, 2'b11, 1'b0, 14'sd0, 0, 32, 1'b0);

    // Noise substitution on slot 31 (L only), then with noise disabled.
    push_exp(-16'sd500, 16'd0, -16'sd500, 16'd0);
    run_frame(31, 14'sd7000, 2'b01, 1'b1, -14'sd500, 0, 32, 1'b1);
    push_exp(16'd7000, 16'd0, 16'd7000, 16'd0);
    run_frame(31, 14'sd7000, 2'b01, 1'b0, -14'sd500, 0, 32, 1'b1);
    // NE ignored away from slot 31.
    push_exp(16'd1000, 16'd0, 16'd1000, 16'd0);
    run_frame(5, 14'sd1000, 2'b01, 1'b1, -14'sd500, 0, 32, 1'b1);
    // No carriers: noise never summed even with NE=1.
    push_exp(16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(99, 14'sd1000, 2'b11, 1'b1, -14'sd500, 0, 32, 1'b1);

    // Saturation: 32 x 8191 = 262112 (trunc 0xFFE0); 32 x -8192 = -262144 (trunc 0).
    push_exp(16'h7FFF, 16'd0, 16'hFFE0, 16'd0);
    run_frame(-1, 14'sd8191, 2'b01, 1'b0, 14'sd0, 0, 32, 1'b1);
    push_exp(16'h8000, 16'd0, 16'h0000, 16'd0);
    run_frame(-1, -14'sd8192, 2'b01, 1'b0, 14'sd0, 0, 32, 1'b1);
    push_exp(16'd0, 16'h7FFF, 16'd0, 16'hFFE0);
    run_frame(-1, 14'sd8191, 2'b10, 1'b0, 14'sd0, 0, 32, 1'b1);

    // Resync at counter 17: partial frame dropped, new frame only.
    run_frame(5, 14'sd1000, 2'b11, 1'b0, 14'sd0, 0, 17, 1'b1);
    push_exp(-16'sd200, -16'sd200, -16'sd200, -16'sd200);
    run_frame(3, -14'sd200, 2'b11, 1'b0, 14'sd0, 0, 32, 1'b1);

    // SYNC coincident with counter 31: no latch, no strobe for the old frame.
    run_frame(5, 14'sd500, 2'b11, 1'b0, 14'sd0, 0, 31, 1'b1);
    push_exp(16'd77, 16'd0, 16'd77, 16'd0);
    run_frame(7, 14'sd77, 2'b01, 1'b0, 14'sd0, 0, 32, 1'b1);

    // Enable gating: 1-3 disabled cycles between enabled ones.
    push_exp(16'd1000, 16'd1000, 16'd1000, 16'd1000);
    run_frame(5, 14'sd1000, 2'b11, 1'b0, 14'sd0, 3, 32, 1'b1);
    @(negedge clk);
    check("hold_acc_l", {16'd0, acc_l}, 32'd1000);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
